// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder (with its 4-bit full_adder slice)
// Brief    : WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock,
//            LSB nibble first, with valid/ready handshakes on both sides.
//            Define NSA_OVERFLOW_EN to add the registered signed-overflow port.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH+3:0] sum_cat;

`ifdef NSA_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_adder u_slice (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  assign sum_cat = {slice_sum, sum_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NSA_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = CALC;
`ifdef NSA_OVERFLOW_EN
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = op_b[WIDTH-1];
`endif
        end
      end
      CALC: begin
        sum_d   = sum_cat[WIDTH+3:4];
        carry_d = slice_cout;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cout_d  = slice_cout;
          state_d = DONE;
`ifdef NSA_OVERFLOW_EN
          // Top slice bit is the result MSB on the final nibble.
          ovf_d   = (a_msb_q == b_msb_q) && (slice_sum[3] != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NSA_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Vector table plus scoreboard bench for nibble_serial_adder (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             cin = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             in_ready;
  logic             out_valid;
  logic             cout;
  logic [WIDTH-1:0] sum;
`ifdef NSA_OVERFLOW_EN
  logic             ovf;
`endif

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   or_mode = 0;  // 0: ready high, 1: random stalls, 2: ready low
  bit   seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: compare on the first cycle each result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid && !seen) begin
      exp_t e;
      seen = 1;
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("latency", 32'(cyc - e.acc), 32'(NIBBLES));
`ifdef NSA_OVERFLOW_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end else if (!out_valid) begin
      seen = 0;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic eco, input logic eov, input bit track);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      return;
    end
    op_a = a;
    op_b = b;
    cin = c;
    in_valid = 1'b1;
    if (track) begin
      e.s = es;
      e.co = eco;
      e.ov = eov;
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] full;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {16'd0, c};
    ov = (a[15] == b[15]) && (full[15] != a[15]);
    send(a, b, c, full[15:0], full[16], ov, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h89AB, 16'h7654, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b1);
    end
    drain();

    // Back-pressure: result must hold and new operands must be ignored.
    or_mode = 2;
    send_model(16'h1111, 16'h2222, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("bp_reach_done", 32'(out_valid), 32'd1);
    end
    op_a = 16'hAAAA;
    op_b = 16'h5555;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum_held", 32'(sum), 32'h3333);
      chk("bp_cout_held", 32'(cout), 32'd0);
    end
    in_valid = 1'b0;
    or_mode = 0;
    @(posedge clk);
    #3;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("bp_no_extra_result", 32'(out_valid), 32'd0);
    chk("bp_sum_kept", 32'(sum), 32'h3333);

    // Reset two cycles into CALC discards the operation.
    send(16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    drain();

    or_mode = 1;
    for (int i = 0; i < 200; i++) begin
      send_model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    or_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that drives the existing 4-bit combinational `full_adder` slice. It feeds the slice one nibble per clock, least-significant nibble first, and carries `cout` into the next nibble's `cin` through a register. Operands arrive and results leave over valid/ready handshakes. The block lets a single 4-bit slice serve wide additions at one nibble per cycle.

## Interface

Parameters:
- `WIDTH`, 16, operand/result width in bits. Must be a multiple of 4 and ≥ 4; elaboration fails otherwise.
- `NIBBLES` (localparam) = WIDTH/4. This is the number of compute cycles.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands and `cin` are valid.
- `in_ready`  output  1  block can accept operands; equals (state == IDLE).
- `op_a`  input  WIDTH  addend A.
- `op_b`  input  WIDTH  addend B.
- `cin`  input  1  carry-in to nibble 0.
- `out_valid`  output  1  `sum`/`cout` hold a completed result.
- `out_ready`  input  1  downstream accepts the result.
- `sum`  output  WIDTH  registered result, {A+B+cin}[WIDTH-1:0].
- `cout`  output  1  registered carry out of bit WIDTH-1.
- `ovf`  output  1  signed overflow; present only with `NSA_OVERFLOW_EN`.

## Operation

- The block contains exactly one `full_adder` instance (ports a, b, cin, sum, cout; 4-bit). No other adder logic is allowed in the sum path.
- FSM states: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`:
  - latch `op_a` and `op_b` into shift registers;
  - load the carry register with `cin`;
  - clear the nibble counter;
  - go to CALC.
- CALC: the slice receives shift-register bits [3:0] and the carry register. On each edge:
  - the slice sum nibble shifts into the result register from the top;
  - the carry register takes the slice `cout`;
  - the operand registers shift right by 4;
  - the counter increments.
- CALC exit: on the edge where counter = NIBBLES-1, go to DONE. At that edge `sum` holds the full result and `cout` holds the final carry.
- DONE: `out_valid`=1. When `out_ready`=1 at an edge, go to IDLE.
- `sum`, `cout` and `ovf` stay stable from entry into DONE until the next accepted operation overwrites them. They are not cleared on return to IDLE.
- Arithmetic: {cout,sum} = op_a + op_b + cin, computed modulo 2^(WIDTH+1). No saturation.

## Timing

- Reset (asynchronous, `rst_n`=0) forces:
  - state=IDLE, so `in_ready`=1;
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0;
  - counter=0, carry register=0.
- Reset during CALC or DONE aborts the operation and discards the result. The first edge after `rst_n` deasserts can accept new operands.
- Latency: if the handshake occurs at edge k, `out_valid` rises after edge k+NIBBLES. For WIDTH=16, that is 4 cycles.
- Throughput: one operation per NIBBLES+2 cycles, achieved with `out_ready` held at 1. `in_ready` is low in CALC and DONE. There is no accept in the same cycle as the result handoff.
- While `in_ready`=0, `in_valid`, `op_a`, `op_b` and `cin` are ignored.
- Back-pressure: with `out_ready`=0 the block stays in DONE indefinitely, with outputs held.
- `out_ready` is ignored outside DONE.
- WIDTH=4 is a legal boundary: CALC lasts one cycle.

## Configuration

- `NSA_OVERFLOW_EN` defined:
  - port `ovf` exists. It is registered on entry to DONE and held like `sum`.
  - ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]), where A and B are the captured operand MSBs.
  - the MSBs are stored in dedicated flops, because the shift registers lose them.
- `NSA_OVERFLOW_EN` undefined: port `ovf` and its flops are absent. All other behaviour is identical.

## Test plan

All scenarios use WIDTH=16.
- Basic add: `op_a`=0x1234, `op_b`=0x4321, `cin`=0, accepted at edge k -> `out_valid` high after edge k+4, `sum`=0x5555, `cout`=0.
- Full carry ripple: `op_a`=0xFFFF, `op_b`=0x0000, `cin`=1 -> `sum`=0x0000, `cout`=1. Also `op_a`=0xFFFF, `op_b`=0xFFFF, `cin`=1 -> `sum`=0xFFFF, `cout`=1.
- Overflow (macro on): 0x8000+0x8000 -> `sum`=0x0000, `cout`=1, `ovf`=1. 0x7FFF+0x0001 -> `sum`=0x8000, `cout`=0, `ovf`=1. 0x0003+0x0004 -> `ovf`=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE and drive `in_valid`=1 with 0xAAAA/0x5555 -> result unchanged, `in_ready`=0, new operands not taken. Raise `out_ready` -> IDLE next cycle, `in_ready`=1.
- Reset mid-CALC: assert `rst_n`=0 two cycles after accepting 0x1234+0x4321 -> `out_valid`=0, `sum`=0 immediately. After release, 0x0001+0x0001 with `cin`=0 -> `sum`=0x0002, `cout`=0.
- Random: 200 random operand/`cin` triples, with random `out_ready` stalls -> each {`cout`,`sum`} equals `op_a`+`op_b`+`cin`, and latency is exactly 4 cycles from accept.
